dram_stream_reader: RTL

AXI3 HP read master that streams a contiguous DRAM buffer into a 64-bit valid/ready stream. It is the read-side counterpart of the DRAM write path and feeds image pipelines from a buffer whose address and length software programs over MMIO. Bursts are issued only when the internal FIFO has reserved space for every beat, so RREADY never throttles the interconnect while a transfer is busy.

---
 rtl/dram_stream_reader.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dram_stream_reader.sv
// AXI3 read master streaming a 128-byte-aligned DRAM buffer out as 64-bit words; R->dout 1 cycle, 1 beat/cycle.
// Backpressure: ARs only issue when FIFO space is reserved for all 16 beats, so RREADY is tied high.
module dram_stream_reader #(
  parameter int FIFO_DEPTH = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] CONFIG_START_ADDR,
  input  logic [31:0] CONFIG_NBYTES,
  input  logic        start,
  output logic        MMIO_READY,
  output logic        error,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  output logic [3:0]  M_AXI_ARLEN,
  output logic [2:0]  M_AXI_ARSIZE,
  output logic [1:0]  M_AXI_ARBURST,
  input  logic [63:0] M_AXI_RDATA,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY,
  input  logic        M_AXI_RLAST,
  input  logic [1:0]  M_AXI_RRESP,
  output logic [63:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [24:0]   bursts_left_q, bursts_left_d;
  logic [28:0]   beats_left_q, beats_left_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          error_q, error_d;
  logic [63:0]   mem_q [FIFO_DEPTH];

  logic          mmio_ready;
  logic          arvalid;
  logic          ar_hs;
  logic          r_wr;
  logic          d_rd;
  logic          credit_ok;
  logic [CW-1:0] reserved;
  logic          unused_ok;

  // Credit counts both buffered words and beats already requested but still in flight.
  assign reserved   = count_q + outst_q;
  assign credit_ok  = (reserved + CW'(16)) <= CW'(FIFO_DEPTH);
  assign ar_hs      = arvalid && M_AXI_ARREADY;
  assign r_wr       = M_AXI_RVALID && (state_q != IDLE);
  assign dout_valid = (count_q != '0);
  assign d_rd       = dout_valid && dout_ready;
  assign unused_ok  = ^{M_AXI_RLAST, CONFIG_START_ADDR[6:0], CONFIG_NBYTES[6:0]};

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && (CONFIG_NBYTES[31:7] != '0)) state_d = RUN;
      RUN:     if (ar_hs && (bursts_left_q == 25'd1)) state_d = DRAIN;
      DRAIN:   if ((beats_left_d == '0) && (count_d == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mmio_ready = 1'b0;
    arvalid    = 1'b0;
    case (state_q)
      IDLE:    mmio_ready = 1'b1;
      RUN:     arvalid = credit_ok && (bursts_left_q != '0) && !RST;
      default: ;
    endcase
  end

  always_comb begin
    addr_d        = addr_q;
    bursts_left_d = bursts_left_q;
    beats_left_d  = beats_left_q;
    error_d       = error_q;
    if ((state_q == IDLE) && start) begin
      addr_d        = {CONFIG_START_ADDR[31:7], 7'b0};
      bursts_left_d = CONFIG_NBYTES[31:7];
      beats_left_d  = {CONFIG_NBYTES[31:7], 4'b0};
      error_d       = 1'b0;
    end
    if (ar_hs) begin
      addr_d        = addr_q + 32'd128;
      bursts_left_d = bursts_left_q - 25'd1;
    end
    if (d_rd) beats_left_d = beats_left_q - 29'd1;
    if (r_wr && (M_AXI_RRESP != 2'b00)) error_d = 1'b1;
    count_d  = count_q + CW'(r_wr) - CW'(d_rd);
    outst_d  = outst_q + (ar_hs ? CW'(16) : CW'(0)) - CW'(r_wr);
    wr_ptr_d = wr_ptr_q + AW'(r_wr);
    rd_ptr_d = rd_ptr_q + AW'(d_rd);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q        <= '0;
      bursts_left_q <= '0;
      beats_left_q  <= '0;
      count_q       <= '0;
      outst_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      error_q       <= 1'b0;
    end else begin
      addr_q        <= addr_d;
      bursts_left_q <= bursts_left_d;
      beats_left_q  <= beats_left_d;
      count_q       <= count_d;
      outst_q       <= outst_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      error_q       <= error_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (r_wr) mem_q[wr_ptr_q] <= M_AXI_RDATA;
  end

  assign dout          = dout_valid ? mem_q[rd_ptr_q] : 64'h0;
  assign MMIO_READY    = mmio_ready;
  assign error         = error_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARVALID = arvalid;
  assign M_AXI_ARLEN   = 4'hF;
  assign M_AXI_ARSIZE  = 3'b011;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_RREADY  = 1'b1;

endmodule
